// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Latency: fixed 32 iterations; done pulses in the cycle after the 32nd edge past accept.
// Backpressure: start is sampled only in IDLE; busy is high through CALC and DONE so the core stalls.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_we
);

  localparam int            CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nx;
  logic [2:0]      fn;
  logic            sa, sb;          // recorded operand signs (0 for unsigned ops)
  logic            b_zero, ovf;     // boundary-case flags captured at accept
  logic [XLEN-1:0] a_lat;           // raw dividend, returned by REM on divide-by-zero
  logic [XLEN-1:0] mb;              // multiplicand (mul) or divisor magnitude (div)
  logic [XLEN-1:0] lo;              // multiplier / product low (mul) or dividend / quotient (div)
  logic [XLEN:0]   acc;             // product high (mul) or remainder with guard bit (div)
  logic [CW-1:0]   count;

  logic            sa_in, sb_in;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN:0]   acc_nx;
  logic [XLEN-1:0] lo_nx;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s, res_sel;

  // Operand sign recording and magnitudes for the op being accepted.
  always_comb begin
    sa_in = op_a[XLEN-1] & (funct3 inside {3'd1, 3'd2, 3'd4, 3'd6});
    sb_in = op_b[XLEN-1] & (funct3 inside {3'd1, 3'd4, 3'd6});
    mag_a = sa_in ? -op_a : op_a;
    mag_b = sb_in ? -op_b : op_b;
  end

  // One iteration of shift-add multiply or restoring divide, plus final result mux.
  always_comb begin
    mul_sum   = {1'b0, acc[XLEN-1:0]} + (lo[0] ? {1'b0, mb} : '0);
    div_shift = {acc[XLEN-1:0], lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, mb};
    if (fn[2]) begin
      // Guard bit set means the trial subtraction borrowed: restore.
      acc_nx = div_diff[XLEN] ? div_shift : div_diff;
      lo_nx  = {lo[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      acc_nx = {1'b0, mul_sum[XLEN:1]};
      lo_nx  = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod   = {acc_nx[XLEN-1:0], lo_nx};
    prod_s = (sa ^ sb) ? -prod : prod;
    quo_s  = (sa ^ sb) ? -lo_nx : lo_nx;
    rem_s  = sa ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    case (fn)
      3'd0:                res_sel = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    res_sel = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:          res_sel = b_zero ? '1 : (ovf ? {1'b1, {(XLEN-1){1'b0}}} : quo_s);
      default:             res_sel = b_zero ? a_lat : (ovf ? '0 : rem_s);
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    wb_we    = 1'b0;
    case (state)
      IDLE: if (start) state_nx = CALC;
      CALC: begin
        busy = 1'b1;
        if (count == LAST) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        wb_we    = (rd_out != 5'd0);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fn     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      b_zero <= 1'b0;
      ovf    <= 1'b0;
      a_lat  <= '0;
      mb     <= '0;
      lo     <= '0;
      acc    <= '0;
      count  <= '0;
      result <= '0;
      rd_out <= '0;
    end else if (state == IDLE && start) begin
      fn     <= funct3;
      sa     <= sa_in;
      sb     <= sb_in;
      b_zero <= (op_b == '0);
      ovf    <= (funct3 inside {3'd4, 3'd6}) && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
      a_lat  <= op_a;
      mb     <= funct3[2] ? mag_b : mag_a;
      lo     <= funct3[2] ? mag_a : mag_b;
      acc    <= '0;
      count  <= '0;
      rd_out <= rd_in;
    end else if (state == CALC) begin
      acc   <= acc_nx;
      lo    <= lo_nx;
      count <= count + 1'b1;
      if (count == LAST) result <= res_sel;
    end
  end

endmodule
